// File: rtl/cascade_divider.sv
// Cascaded reloadable down-counter divider (STAGES x WIDTH); optional lap snapshot via CASCADE_DIVIDER_SNAPSHOT_EN.
// Latency: tc strobes are combinational (zero latency); counts and done update on the next posedge.
// Backpressure: none; ena low freezes the chain in place, done freezes it until rst or clr.
module cascade_divider #(
    parameter int WIDTH  = 19,
    parameter int STAGES = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ena,
    input  logic                    clr,
    input  logic                    oneshot,
    input  logic [STAGES*WIDTH-1:0] i_count,
`ifdef CASCADE_DIVIDER_SNAPSHOT_EN
    input  logic                    snap,
    output logic [STAGES*WIDTH-1:0] snap_count,
`endif
    output logic [STAGES*WIDTH-1:0] count,
    output logic [STAGES-1:0]       tc,
    output logic                    done
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [STAGES-1:0] zero;
    logic [STAGES-1:0] en;
    logic              carry;

    for (genvar g = 0; g < STAGES; g++) begin : g_zero
        assign zero[g] = (count[g*WIDTH +: WIDTH] == '0);
    end

    // carry ripples up the chain: a stage advances only while every lower stage is at its terminal count
    always_comb begin
        en    = '0;
        tc    = '0;
        carry = ena & ~done & rst & ~clr;
        for (int k = 0; k < STAGES; k++) begin
            en[k] = carry;
            tc[k] = carry & zero[k];
            carry = carry & zero[k];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            count <= i_count;
            done  <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    count[k*WIDTH +: WIDTH] <= zero[k] ? i_count[k*WIDTH +: WIDTH]
                                                       : count[k*WIDTH +: WIDTH] - ONE;
                end
            end
            if (oneshot && tc[STAGES-1]) begin
                done <= 1'b1;
            end
        end
    end

`ifdef CASCADE_DIVIDER_SNAPSHOT_EN
    // lap capture takes the pre-update value of all stages in one edge; clr deliberately leaves it alone
    always_ff @(posedge clk) begin
        if (!rst) begin
            snap_count <= '0;
        end else if (snap) begin
            snap_count <= count;
        end
    end
`endif

endmodule

// File: doc/cascade_divider.md
Name: cascade_divider

Overview:
- Parametrised successor to the single-stage programmable down-counter divider.
- Chains STAGES down-counters of WIDTH bits. Stage 0 advances on `ena`; each higher stage advances only on the terminal count of every lower stage.
- Serves as the stopwatch timebase, e.g. 100 MHz → 1 kHz → 100 Hz → 1 Hz.
- Adds periodic or one-shot mode, synchronous clear, and per-stage terminal-count strobes.

Parameters:
- WIDTH, 19, bit width of each stage counter and each terminal-value slice.
- STAGES, 3, number of cascaded stages; STAGES ≥ 1.

Ports:
- clk  input  1  sole clock; all state updates on posedge.
- rst  input  1  synchronous, active-low reset.
- ena  input  1  count enable for stage 0.
- clr  input  1  synchronous clear; active high.
- oneshot  input  1  1 = stop after the first terminal count of the last stage; 0 = periodic.
- i_count  input  STAGES*WIDTH  terminal (reload) value per stage; slice k = bits [k*WIDTH +: WIDTH].
- count  output  STAGES*WIDTH  current value of each stage counter.
- tc  output  STAGES  per-stage terminal-count strobe.
- done  output  1  one-shot completion flag.

Behaviour:
- Priority: rst low > clr high > done-hold > counting.
- rst low at posedge:
  - every count slice ← i_count slice; done ← 0.
  - tc forced to 0 in any cycle where rst is low.
- clr high (rst high): same effect as reset — counts reload, done ← 0, tc forced 0.
- Stage enable:
  - en[0] = ena & ~done.
  - en[k] = en[k-1] & tc[k-1].
- tc is combinational, zero latency: tc[k] = en[k] & (count[k] == 0) & rst & ~clr.
- Stage update at posedge, when en[k]:
  - count[k] == 0 → count[k] ← i_count[k] (reload);
  - otherwise count[k] ← count[k] − 1.
  - When ~en[k], count[k] holds.
- Period:
  - stage k divides its enable by i_count[k] + 1.
  - The full chain divides `ena` by the product of (i_count[k] + 1).
- i_count sampling:
  - a slice is read only at reset, at clr, or at that stage's reload.
  - Mid-period changes take effect from the next reload; there is no glitch in the current period.
- i_count slice = 0: divide-by-1; tc[k] = en[k] every enabled cycle.
- Wrap-around: the counter never underflows; value 0 always reloads. No arithmetic beyond WIDTH bits.
- One-shot mode:
  - when oneshot = 1 and tc[STAGES-1] = 1 at a posedge, done ← 1. Stages still reload on that edge.
  - While done = 1: all counts hold, all tc = 0, `ena` is ignored.
  - done clears only via rst or clr.
  - oneshot is sampled only at that edge; dropping oneshot while done = 1 does not resume counting.
- Periodic mode (oneshot = 0): done stays 0; the chain wraps indefinitely.
- `ena` deasserted mid-period: all stages hold their values; resumes exactly where it stopped.
- Reset or clr mid-operation: an immediate full reload; no partial-period strobes.
- Outputs after reset: count = i_count slices, tc = 0, done = 0.

Optional Feature:
- Macro: CASCADE_DIVIDER_SNAPSHOT_EN.
- Defined: adds input `snap` (1 bit) and output `snap_count` (STAGES*WIDTH bits).
  - On a posedge with snap = 1 and rst high, snap_count ← the current count value (pre-update), atomically across all stages. This provides the stopwatch lap capture.
  - snap_count resets to 0 on rst low and is unaffected by clr.
  - snap_count holds otherwise.
- Undefined: `snap` and `snap_count` do not exist; no extra registers.

Test Plan:
1. Basic cascade: WIDTH = 4, STAGES = 2, i_count = {4'd3, 4'd2}, ena = 1, oneshot = 0 → tc[0] on cycles 3, 6, 9, …; tc[1] on cycles 12, 24, … coincident with tc[0]. count = {3, 2} after reset.
2. Gated enable: same configuration, ena toggles 1, 0, 1, 0, … → tc[0] at every 3rd enabled cycle only; count holds on ena = 0 cycles.
3. One-shot: i_count = {4'd1, 4'd1}, oneshot = 1, ena = 1 → tc[1] and done rise after 4 cycles. Afterwards count = {1, 1}, tc = 0, done = 1 held for 20 cycles; clr pulse → done = 0, counting resumes.
4. Divide-by-1 and reload latching: i_count slice 0 = 0 → tc[0] every cycle. Change slice 0 from 5 to 2 at count[0] = 3 → the current period finishes at 0, and the next period is 3 cycles.
5. Reset mid-operation: rst low at count = {2, 1} with ena = 1 → next edge count = i_count, tc = 0 during reset, done = 0.
6. With CASCADE_DIVIDER_SNAPSHOT_EN: snap pulse at count = {3, 1} → snap_count = {3, 1} next cycle, held while the chain continues. A clr pulse leaves snap_count unchanged.
